// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - streamed image writer with readback checksum verify and core reset hold
module prog_loader #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int VERIFY     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] length,
    input  logic                  din_valid,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  din_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_dout,
    input  logic [DATA_WIDTH-1:0] mem_din,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  cpu_reset_n
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] WRITE      = 3'd1;
    localparam logic [2:0] VERIFY_REQ = 3'd2;
    localparam logic [2:0] VERIFY_CHK = 3'd3;
    localparam logic [2:0] DONE       = 3'd4;
    localparam logic [2:0] ERROR      = 3'd5;

    logic [2:0]            state;
    logic [2:0]            state_nxt;
    logic [ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH-1:0] len;
    logic [ADDR_WIDTH-1:0] count;
    logic [ADDR_WIDTH-1:0] rcount;
    logic [ADDR_WIDTH-1:0] count_inc;
    logic [ADDR_WIDTH-1:0] rcount_inc;
    logic [DATA_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0] rd_sum;
    logic [DATA_WIDTH-1:0] rd_sum_nxt;
    logic                  handshake;
    logic                  accept_start;

    assign din_ready    = (state == WRITE);
    assign handshake    = din_valid && din_ready;
    assign accept_start = start && ((state == IDLE) || (state == DONE) || (state == ERROR));
    assign count_inc    = count + ADDR_WIDTH'(1);
    assign rcount_inc   = rcount + ADDR_WIDTH'(1);
    assign rd_sum_nxt   = rd_sum + mem_din;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_nxt = (length == '0) ? DONE : WRITE;
                end
            end
            WRITE: begin
                if (handshake && (count_inc == len)) begin
                    state_nxt = (VERIFY != 0) ? VERIFY_REQ : DONE;
                end
            end
            VERIFY_REQ: state_nxt = VERIFY_CHK;
            VERIFY_CHK: begin
                if (rcount_inc < len) begin
                    state_nxt = VERIFY_REQ;
                end else begin
                    state_nxt = (rd_sum_nxt == sum) ? DONE : ERROR;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            base        <= '0;
            len         <= '0;
            count       <= '0;
            rcount      <= '0;
            sum         <= '0;
            rd_sum      <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_dout    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            cpu_reset_n <= 1'b0;
        end else begin
            state       <= state_nxt;
            mem_we      <= 1'b0;
            busy        <= (state_nxt == WRITE) || (state_nxt == VERIFY_REQ) ||
                           (state_nxt == VERIFY_CHK);
            done        <= (state_nxt == DONE);
            error       <= (state_nxt == ERROR);
            cpu_reset_n <= (state_nxt == DONE);

            if (accept_start) begin
                base   <= base_addr;
                len    <= length;
                count  <= '0;
                rcount <= '0;
                sum    <= '0;
                rd_sum <= '0;
            end

            case (state)
                WRITE: begin
                    if (handshake) begin
                        mem_we   <= 1'b1;
                        mem_addr <= base + count;
                        mem_dout <= din;
                        sum      <= sum + din;
                        count    <= count_inc;
                    end
                end
                VERIFY_REQ: mem_addr <= base + rcount;
                VERIFY_CHK: begin
                    rd_sum <= rd_sum_nxt;
                    rcount <= rcount_inc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] length;
    logic        din_valid;
    logic [7:0]  din;
    logic        din_ready;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_reset_n;

    int          vec_n = 0;
    int          miss_n = 0;

    logic [7:0]  mem [0:65535];
    logic        corrupt = 1'b0;
    logic [15:0] wr_addr [0:1023];
    logic [7:0]  wr_data [0:1023];
    int          wr_n = 0;
    logic [7:0]  img [0:3];

    always #5 clk = ~clk;

    prog_loader dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .base_addr   (base_addr),
        .length      (length),
        .din_valid   (din_valid),
        .din         (din),
        .din_ready   (din_ready),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_dout    (mem_dout),
        .mem_din     (mem_din),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .cpu_reset_n (cpu_reset_n)
    );

    // Memory model: registered write, combinational read; optional corruption at 0x0012.
    assign mem_din = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            mem[mem_addr]  <= (corrupt && mem_addr == 16'h0012) ? 8'h86 : mem_dout;
            wr_addr[wr_n]  <= mem_addr;
            wr_data[wr_n]  <= mem_dout;
            wr_n           <= wr_n + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [15:0] b, input logic [15:0] l);
        base_addr = b;
        length    = l;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic feed(input int first, input int n, input logic [7:0] pat, output int got);
        int   idx;
        logic hs;
        idx = first;
        for (int k = 0; k < 64 && idx < n; k++) begin
            din_valid = pat[k % 8];
            din       = img[idx];
            hs        = din_valid && din_ready;
            tick();
            if (hs) idx++;
        end
        din_valid = 1'b0;
        got = idx;
    endtask

    task automatic wait_done(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int k = 0; k < budget; k++) begin
            if (done || error) break;
            tick();
        end
        if (done || error) timed_out = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; din_valid = 1'b0; din = 8'h00;
        base_addr = 16'h0000; length = 16'h0000;
        tick();
        tick();
        vec_n++;
        if ({mem_we, busy, done, error, cpu_reset_n, din_ready} !== 6'b0) begin
            miss_n++;
            $display("FAIL reset_flags: got %b want 000000", {mem_we, busy, done, error, cpu_reset_n, din_ready});
        end
        vec_n++;
        if ({mem_addr, mem_dout} !== 24'h0) begin
            miss_n++;
            $display("FAIL reset_mem_bus: got %h/%h want 0000/00", mem_addr, mem_dout);
        end
        reset = 1'b0;
        tick();
        vec_n++;
        if ({busy, done, cpu_reset_n} !== 3'b000) begin
            miss_n++;
            $display("FAIL idle_flags: got %b want 000", {busy, done, cpu_reset_n});
        end
    endtask

    task automatic test_basic();
        logic [15:0] ea;
        int          w0;
        img[0] = 8'hA9; img[1] = 8'h04; img[2] = 8'h85; img[3] = 8'h02;
        w0 = wr_n;
        base_addr = 16'h0010; length = 16'd4; start = 1'b1;
        din_valid = 1'b1; din = 8'hEE;
        vec_n++;
        if (din_ready !== 1'b0) begin
            miss_n++;
            $display("FAIL idle_din_ready: got %b want 0", din_ready);
        end
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            din = img[i];
            din_valid = 1'b1;
            tick();
            ea = 16'h0010 + 16'(i);
            vec_n++;
            if ({mem_we, mem_addr, mem_dout} !== {1'b1, ea, img[i]}) begin
                miss_n++;
                $display("FAIL basic_write[%0d]: got we=%b a=%h d=%h want we=1 a=%h d=%h",
                         i, mem_we, mem_addr, mem_dout, ea, img[i]);
            end
        end
        vec_n++;
        if (din_ready !== 1'b0) begin
            miss_n++;
            $display("FAIL basic_ready_drop: got %b want 0", din_ready);
        end
        din_valid = 1'b0;
        for (int j = 5; j <= 11; j++) begin
            tick();
            vec_n++;
            if ({mem_we, done, busy} !== 3'b001) begin
                miss_n++;
                $display("FAIL basic_verify[%0d]: got we/done/busy=%b want 001", j, {mem_we, done, busy});
            end
        end
        tick();
        vec_n++;
        if ({done, cpu_reset_n, busy, error} !== 4'b1100) begin
            miss_n++;
            $display("FAIL basic_done_at_13: got done/crn/busy/err=%b want 1100", {done, cpu_reset_n, busy, error});
        end
        vec_n++;
        if ((wr_n - w0) !== 4) begin
            miss_n++;
            $display("FAIL basic_write_count: got %0d want 4", wr_n - w0);
        end
    endtask

    task automatic test_backpressure();
        int          got;
        bit          to;
        int          w0;
        logic [15:0] ea;
        w0 = wr_n;
        pulse_start(16'h0010, 16'd4);
        feed(0, 4, 8'b1001_1001, got);
        wait_done(40, to);
        vec_n++;
        if ({to, done, error} !== 3'b010) begin
            miss_n++;
            $display("FAIL bp_done: got timeout/done/err=%b want 010", {to, done, error});
        end
        vec_n++;
        if ((wr_n - w0) !== 4) begin
            miss_n++;
            $display("FAIL bp_write_count: got %0d want 4", wr_n - w0);
        end
        for (int i = 0; i < 4; i++) begin
            ea = 16'h0010 + 16'(i);
            vec_n++;
            if ({wr_addr[w0 + i], wr_data[w0 + i], mem[ea]} !== {ea, img[i], img[i]}) begin
                miss_n++;
                $display("FAIL bp_write[%0d]: got a=%h d=%h mem=%h want a=%h d=%h",
                         i, wr_addr[w0 + i], wr_data[w0 + i], mem[ea], ea, img[i]);
            end
        end
    endtask

    task automatic test_checksum_error();
        int got;
        bit to;
        corrupt = 1'b1;
        pulse_start(16'h0010, 16'd4);
        feed(0, 4, 8'hFF, got);
        wait_done(40, to);
        corrupt = 1'b0;
        vec_n++;
        if ({to, error, done, cpu_reset_n} !== 4'b0100) begin
            miss_n++;
            $display("FAIL csum_error: got timeout/err/done/crn=%b want 0100", {to, error, done, cpu_reset_n});
        end
        tick(); tick(); tick();
        vec_n++;
        if ({error, cpu_reset_n, busy} !== 3'b100) begin
            miss_n++;
            $display("FAIL csum_error_hold: got err/crn/busy=%b want 100", {error, cpu_reset_n, busy});
        end
    endtask

    task automatic test_len_zero();
        int w0;
        w0 = wr_n;
        pulse_start(16'h0040, 16'd0);
        vec_n++;
        if ({done, cpu_reset_n, busy, error, mem_we} !== 5'b11000) begin
            miss_n++;
            $display("FAIL len0_done: got done/crn/busy/err/we=%b want 11000", {done, cpu_reset_n, busy, error, mem_we});
        end
        tick(); tick(); tick();
        vec_n++;
        if (wr_n !== w0) begin
            miss_n++;
            $display("FAIL len0_no_write: got %0d writes want 0", wr_n - w0);
        end
    endtask

    task automatic test_wrap();
        int          got;
        bit          to;
        int          w0;
        logic [15:0] exp_a [0:3];
        exp_a[0] = 16'hFFFE; exp_a[1] = 16'hFFFF; exp_a[2] = 16'h0000; exp_a[3] = 16'h0001;
        img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33; img[3] = 8'h44;
        w0 = wr_n;
        pulse_start(16'hFFFE, 16'd4);
        feed(0, 4, 8'hFF, got);
        wait_done(40, to);
        vec_n++;
        if ({to, done, error} !== 3'b010) begin
            miss_n++;
            $display("FAIL wrap_done: got timeout/done/err=%b want 010", {to, done, error});
        end
        for (int i = 0; i < 4; i++) begin
            vec_n++;
            if ({wr_addr[w0 + i], wr_data[w0 + i]} !== {exp_a[i], img[i]}) begin
                miss_n++;
                $display("FAIL wrap_write[%0d]: got a=%h d=%h want a=%h d=%h",
                         i, wr_addr[w0 + i], wr_data[w0 + i], exp_a[i], img[i]);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        int got;
        int w0;
        img[0] = 8'hA9; img[1] = 8'h04; img[2] = 8'h85; img[3] = 8'h02;
        pulse_start(16'h0010, 16'd4);
        w0 = wr_n;
        feed(0, 2, 8'hFF, got);
        reset = 1'b1;
        din_valid = 1'b1;
        din = img[2];
        tick();
        vec_n++;
        if ({mem_we, busy, done, error, cpu_reset_n, din_ready} !== 6'b0) begin
            miss_n++;
            $display("FAIL midreset_flags: got we/busy/done/err/crn/rdy=%b want 000000",
                     {mem_we, busy, done, error, cpu_reset_n, din_ready});
        end
        reset = 1'b0;
        tick(); tick(); tick();
        din_valid = 1'b0;
        vec_n++;
        if ((wr_n - w0) !== 2) begin
            miss_n++;
            $display("FAIL midreset_write_count: got %0d want 2", wr_n - w0);
        end
    endtask

    task automatic test_start_busy_restart();
        int          got;
        bit          to;
        int          w0;
        logic [15:0] ea;
        img[0] = 8'hA9; img[1] = 8'h04; img[2] = 8'h85; img[3] = 8'h02;
        w0 = wr_n;
        pulse_start(16'h0010, 16'd4);
        din_valid = 1'b1; din = img[0];
        base_addr = 16'h0020; length = 16'd2; start = 1'b1;
        tick();
        start = 1'b0;
        feed(1, 4, 8'hFF, got);
        wait_done(40, to);
        vec_n++;
        if ({to, done, (wr_n - w0) == 4} !== 3'b011) begin
            miss_n++;
            $display("FAIL busy_start_load: got timeout/done=%b writes=%0d want 01 writes=4", {to, done}, wr_n - w0);
        end
        for (int i = 0; i < 4; i++) begin
            ea = 16'h0010 + 16'(i);
            vec_n++;
            if ({wr_addr[w0 + i], wr_data[w0 + i]} !== {ea, img[i]}) begin
                miss_n++;
                $display("FAIL busy_start_write[%0d]: got a=%h d=%h want a=%h d=%h",
                         i, wr_addr[w0 + i], wr_data[w0 + i], ea, img[i]);
            end
        end
        img[0] = 8'h5A; img[1] = 8'hA5;
        w0 = wr_n;
        pulse_start(16'h0020, 16'd2);
        vec_n++;
        if ({cpu_reset_n, done, busy} !== 3'b001) begin
            miss_n++;
            $display("FAIL restart_reset_core: got crn/done/busy=%b want 001", {cpu_reset_n, done, busy});
        end
        feed(0, 2, 8'hFF, got);
        wait_done(40, to);
        vec_n++;
        if ({to, done, cpu_reset_n, (wr_n - w0) == 2} !== 4'b0111) begin
            miss_n++;
            $display("FAIL restart_done: got timeout/done/crn=%b writes=%0d want 011 writes=2",
                     {to, done, cpu_reset_n}, wr_n - w0);
        end
        vec_n++;
        if ({wr_addr[w0], wr_data[w0], wr_addr[w0 + 1], wr_data[w0 + 1]} !== {16'h0020, 8'h5A, 16'h0021, 8'hA5}) begin
            miss_n++;
            $display("FAIL restart_writes: got %h:%h %h:%h want 0020:5a 0021:a5",
                     wr_addr[w0], wr_data[w0], wr_addr[w0 + 1], wr_data[w0 + 1]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_checksum_error();
        test_len_zero();
        test_wrap();
        test_reset_mid_load();
        test_start_busy_restart();
        $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Memory-side writer that fills program/data memory before the core runs; it is the counterpart of the fetcher, which reads the same memory.
- Accepts a byte stream over a valid/ready handshake and writes it to consecutive addresses from a programmable base.
- Reads the written region back and checks it against a running 8-bit sum.
- Holds the core in reset until the image is loaded and verified, then releases it.
- Sits between an external loader source and the mem write port, and is muxed against the fetcher address path by cpu_reset_n.

Parameters:
- ADDR_WIDTH, 16, width of memory address and length.
- DATA_WIDTH, 8, width of a memory word.
- VERIFY, 1, 1 = perform readback checksum pass after writing; 0 = go straight to DONE.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; latches base_addr and length.
- base_addr  in  ADDR_WIDTH  first address to write.
- length  in  ADDR_WIDTH  number of words to load; 0 is legal.
- din_valid  in  1  stream byte valid.
- din  in  DATA_WIDTH  stream byte.
- din_ready  out  1  loader can accept din this cycle.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_dout  out  DATA_WIDTH  write data to memory.
- mem_din  in  DATA_WIDTH  read data from memory; valid the cycle after mem_addr is presented.
- busy  out  1  high in WRITE, VERIFY_REQ and VERIFY_CHK.
- done  out  1  high in DONE.
- error  out  1  high in ERROR.
- cpu_reset_n  out  1  low holds core in reset; high only in DONE.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; count, sum and rd_sum cleared.
  - mem_we = 0, mem_addr = 0, mem_dout = 0.
  - din_ready, busy, done and error = 0; cpu_reset_n = 0.
- Reset mid-operation aborts immediately: no further write is issued the cycle after reset is sampled.
- All outputs are registered except din_ready, which is decoded from state only (1 in WRITE).
- IDLE:
  - start=1 latches base and len, clears count, sum and rd_sum.
  - Goes to DONE if len==0, else to WRITE.
- WRITE:
  - Handshake = din_valid & din_ready.
  - On handshake at cycle N, the cycle-N+1 outputs are mem_we=1, mem_addr=base+count (mod 2^ADDR_WIDTH), mem_dout=din.
  - On handshake, sum += din (mod 2^DATA_WIDTH) and count++.
  - With no handshake, mem_we=0 the next cycle.
  - After handshake number len (count reaches len), go to VERIFY_REQ if VERIFY=1, else to DONE.
  - din_ready drops in the cycle after the final handshake.
- VERIFY_REQ:
  - Present mem_addr = base + rcount with mem_we=0, then go to VERIFY_CHK.
- VERIFY_CHK:
  - rd_sum += mem_din and rcount++.
  - If rcount < len, go back to VERIFY_REQ.
  - Otherwise compare: if (rd_sum + mem_din) == sum go to DONE, else go to ERROR.
  - Verify therefore costs 2 cycles per word.
- DONE:
  - done=1, cpu_reset_n=1.
  - start=1 re-enters the load sequence exactly as from IDLE, driving cpu_reset_n=0 on the next cycle.
- ERROR:
  - error=1, cpu_reset_n=0.
  - Left only by reset or start (restart as from IDLE).
- start while busy is ignored; latched base and len are unchanged.
- Address wrap: base+count wraps modulo 2^ADDR_WIDTH, with no error flagged.
- Simultaneous start and din_valid in IDLE: the byte is not accepted (din_ready=0 in IDLE).
- Write timing: mem_we is never high for two different addresses in the same cycle, and is never high outside the cycle following a handshake.

Test Plan:
- Basic load:
  - Stimulus: reset 2 cycles; start with base=0x0010, len=4; stream A9,04,85,02 with din_valid held high.
  - Response: mem_we pulses at addr 0x10..0x13 with those bytes on consecutive cycles; verify passes with sum=0x34; done=1 and cpu_reset_n=1 at cycle 1+4+8 after start.
- Backpressure:
  - Stimulus: same image, din_valid toggled 1,0,0,1,...
  - Response: writes occur only after handshakes, addresses stay contiguous, final memory is identical to the basic load.
- Checksum error:
  - Stimulus: bench memory model corrupts addr 0x12 to 0x86 after it is written.
  - Response: rd_sum=0x35 ≠ 0x34; error=1, cpu_reset_n stays 0, done=0.
- Length zero and wrap:
  - Stimulus: start with len=0.
  - Response: DONE the next cycle with no mem_we.
  - Stimulus: start with base=0xFFFE, len=4.
  - Response: writes go to 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Reset mid-load:
  - Stimulus: assert reset after 2 of 4 bytes.
  - Response: the next cycle shows state IDLE, mem_we=0, cpu_reset_n=0, din_ready=0; the remaining bytes are not written.
- start while busy, then restart from DONE:
  - Stimulus: pulse start with base=0x0020 during WRITE.
  - Response: ignored; the load continues at 0x10.
  - Stimulus: start again from DONE.
  - Response: cpu_reset_n=0 the next cycle and a new load begins at the new base.
